// File: rtl/eth_stats_pkg.sv
// Shared types and helpers for the Ethernet frame statistics monitor.
//   stats_mode_e   : which side of the MAC the tap watches (TX or RX)
//   mon_state_e    : frame delimiter state
//   frame_flags_t  : status part of the per-frame record
//   popcount_keep  : number of enabled bytes in a tkeep vector (up to 8 lanes)
package eth_stats_pkg;

  typedef enum logic [0:0] {
    STATS_MODE_TX = 1'b0,
    STATS_MODE_RX = 1'b1
  } stats_mode_e;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } mon_state_e;

  typedef struct packed {
    logic good;
    logic runt;
    logic oversize;
  } frame_flags_t;

  localparam int unsigned KEEP_MAX_W = 8;

  // tkeep is contiguous from bit 0, but counting every bit keeps the helper
  // correct even for a malformed keep pattern.
  function automatic logic [3:0] popcount_keep(input logic [KEEP_MAX_W-1:0] keep);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      cnt = cnt + {3'd0, keep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/eth_stats_totals.sv
// Running totals for completed frames with an atomic snapshot.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   add_valid_i         : a frame record is valid this cycle
//   add_bytes_i         : byte count of that frame
//   add_bad_i           : that frame was bad
//   snap_req_i          : latch the totals (including this cycle's frame)
//   snap_frames_o       : snapshot of completed frames
//   snap_bytes_o        : snapshot of summed frame bytes
//   snap_bad_o          : snapshot of bad frames
//   snap_valid_o        : one-cycle pulse after snap_req_i
module eth_stats_totals #(
  parameter int unsigned LEN_W         = 16,
  parameter int unsigned CNT_W         = 64,
  parameter int unsigned CLEAR_ON_SNAP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_valid_i,
  input  logic [LEN_W-1:0] add_bytes_i,
  input  logic             add_bad_i,
  input  logic             snap_req_i,
  output logic [CNT_W-1:0] snap_frames_o,
  output logic [CNT_W-1:0] snap_bytes_o,
  output logic [CNT_W-1:0] snap_bad_o,
  output logic             snap_valid_o
);

  logic [CNT_W-1:0] frames_q, bytes_q, bad_q;
  logic [CNT_W-1:0] frames_d, bytes_d, bad_d;
  logic [CNT_W-1:0] snap_frames_q, snap_bytes_q, snap_bad_q;
  logic [CNT_W-1:0] snap_frames_d, snap_bytes_d, snap_bad_d;
  logic [CNT_W-1:0] frames_upd_s, bytes_upd_s, bad_upd_s;
  logic             snap_valid_q;

  // Post-update totals; the snapshot takes these so a same-cycle frame is included.
  always_comb begin
    frames_upd_s = frames_q + CNT_W'(add_valid_i);
    bytes_upd_s  = bytes_q + (add_valid_i ? CNT_W'(add_bytes_i) : {CNT_W{1'b0}});
    bad_upd_s    = bad_q + CNT_W'(add_valid_i & add_bad_i);
  end

  // Next live totals and snapshot registers; on clear a same-cycle frame lands
  // only in the snapshot, never in the restarted live totals.
  always_comb begin
    frames_d      = frames_upd_s;
    bytes_d       = bytes_upd_s;
    bad_d         = bad_upd_s;
    snap_frames_d = snap_frames_q;
    snap_bytes_d  = snap_bytes_q;
    snap_bad_d    = snap_bad_q;
    if (snap_req_i) begin
      snap_frames_d = frames_upd_s;
      snap_bytes_d  = bytes_upd_s;
      snap_bad_d    = bad_upd_s;
      if (CLEAR_ON_SNAP != 32'd0) begin
        frames_d = {CNT_W{1'b0}};
        bytes_d  = {CNT_W{1'b0}};
        bad_d    = {CNT_W{1'b0}};
      end else begin
        frames_d = frames_upd_s;
      end
    end else begin
      snap_valid_dummy_guard();
    end
  end

  // Live totals, snapshot registers and snapshot pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frames_q      <= {CNT_W{1'b0}};
      bytes_q       <= {CNT_W{1'b0}};
      bad_q         <= {CNT_W{1'b0}};
      snap_frames_q <= {CNT_W{1'b0}};
      snap_bytes_q  <= {CNT_W{1'b0}};
      snap_bad_q    <= {CNT_W{1'b0}};
      snap_valid_q  <= 1'b0;
    end else begin
      frames_q      <= frames_d;
      bytes_q       <= bytes_d;
      bad_q         <= bad_d;
      snap_frames_q <= snap_frames_d;
      snap_bytes_q  <= snap_bytes_d;
      snap_bad_q    <= snap_bad_d;
      snap_valid_q  <= snap_req_i;
    end
  end

  // Empty helper that marks the no-snapshot branch.
  function automatic void snap_valid_dummy_guard();
  endfunction

  assign snap_frames_o = snap_frames_q;
  assign snap_bytes_o  = snap_bytes_q;
  assign snap_bad_o    = snap_bad_q;
  assign snap_valid_o  = snap_valid_q;

endmodule

// File: rtl/eth_frame_stats_monitor.sv
// Passive AXI-Stream tap that delimits Ethernet frames, counts bytes via tkeep,
// flags underrun/error/runt/oversize, emits one record per frame and keeps
// running totals with an atomic snapshot. Never drives the stream.
// Ports:
//   clk, rst_n                        : clock, synchronous active-low reset
//   axis_tready/tvalid/tlast/tkeep    : monitored stream (tkeep contiguous from bit 0)
//   axis_tuser                        : RX error, sampled on the tlast beat (RX mode only)
//   snapshot_req                      : single-cycle pulse, latch totals
//   frame_bytes/good/runt/oversize    : record of the last completed frame
//   frame_valid                       : one-cycle pulse when the record updates
//   snap_frames/bytes/bad, snap_valid : snapshot of the running totals
// LEN_W must be at least 4 so one beat's byte count fits the accumulator.
module eth_frame_stats_monitor
  import eth_stats_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned MODE          = 0,
  parameter int unsigned LEN_W         = 16,
  parameter int unsigned MIN_LEN       = 64,
  parameter int unsigned MAX_LEN       = 1522,
  parameter int unsigned CNT_W         = 64,
  parameter int unsigned CLEAR_ON_SNAP = 0,
  localparam int unsigned KEEP_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              axis_tready,
  input  logic              axis_tvalid,
  input  logic              axis_tlast,
  input  logic [KEEP_W-1:0] axis_tkeep,
  input  logic              axis_tuser,
  input  logic              snapshot_req,
  output logic [LEN_W-1:0]  frame_bytes,
  output logic              frame_good,
  output logic              frame_runt,
  output logic              frame_oversize,
  output logic              frame_valid,
  output logic [CNT_W-1:0]  snap_frames,
  output logic [CNT_W-1:0]  snap_bytes,
  output logic [CNT_W-1:0]  snap_bad,
  output logic              snap_valid
);

  localparam stats_mode_e MODE_E = (MODE == 32'd1) ? STATS_MODE_RX : STATS_MODE_TX;
  localparam logic [LEN_W-1:0]  LEN_SAT = {LEN_W{1'b1}};
  // Thresholds compared at LEN_W+32 bits so a narrow LEN_W never truncates them.
  localparam logic [LEN_W+31:0] MIN_EXT = (LEN_W + 32)'(MIN_LEN);
  localparam logic [LEN_W+31:0] MAX_EXT = (LEN_W + 32)'(MAX_LEN);

  mon_state_e        state_q, state_d;
  logic [LEN_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  frame_bytes_q;
  frame_flags_t      flags_q, flags_d;
  logic              frame_valid_q;

  logic              beat_s;
  logic              underrun_s;
  logic              end_s;
  logic              good_end_s;
  logic [7:0]        keep_ext_s;
  logic [LEN_W-1:0]  beat_bytes_s;
  logic [LEN_W-1:0]  base_s;
  logic [LEN_W:0]    wide_sum_s;
  logic [LEN_W-1:0]  sum_s;
  logic [LEN_W-1:0]  bytes_end_s;
  logic [LEN_W+31:0] bytes_ext_s;

  assign beat_s     = axis_tready & axis_tvalid;
  assign keep_ext_s = 8'(axis_tkeep);
  // Only TX treats a ready-but-not-valid cycle inside a frame as an underrun.
  assign underrun_s = (MODE_E == STATS_MODE_TX) & (state_q == ST_IN_FRAME) &
                      axis_tready & ~axis_tvalid;

  // Saturating add of this beat's bytes; a fresh frame starts from zero.
  always_comb begin
    beat_bytes_s = LEN_W'(popcount_keep(keep_ext_s));
    base_s       = (state_q == ST_IN_FRAME) ? acc_q : {LEN_W{1'b0}};
    wide_sum_s   = {1'b0, base_s} + {1'b0, beat_bytes_s};
    if (wide_sum_s[LEN_W]) begin
      sum_s = LEN_SAT;
    end else begin
      sum_s = wide_sum_s[LEN_W-1:0];
    end
  end

  // Frame delimiter next-state logic; also decides when a frame ends and how.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    end_s       = 1'b0;
    good_end_s  = 1'b1;
    bytes_end_s = acc_q;
    case (state_q)
      ST_IDLE, ST_IN_FRAME: begin
        if (beat_s) begin
          if (axis_tlast) begin
            end_s       = 1'b1;
            bytes_end_s = sum_s;
            good_end_s  = (MODE_E == STATS_MODE_RX) ? ~axis_tuser : 1'b1;
            state_d     = ST_IDLE;
            acc_d       = {LEN_W{1'b0}};
          end else begin
            state_d = ST_IN_FRAME;
            acc_d   = sum_s;
          end
        end else if (underrun_s) begin
          // Underrun closes the frame with the bytes seen so far.
          end_s       = 1'b1;
          bytes_end_s = acc_q;
          good_end_s  = 1'b0;
          state_d     = ST_IDLE;
          acc_d       = {LEN_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = {LEN_W{1'b0}};
      end
    endcase
  end

  // Record flags for the frame that ends this cycle (saturated count is compared).
  always_comb begin
    bytes_ext_s      = (LEN_W + 32)'(bytes_end_s);
    flags_d.good     = good_end_s;
    flags_d.runt     = (bytes_ext_s < MIN_EXT);
    flags_d.oversize = (MAX_LEN != 32'd0) && (bytes_ext_s > MAX_EXT);
  end

  // Delimiter state and byte accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= {LEN_W{1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Per-frame record, loaded the cycle after the ending beat and held until the next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_bytes_q <= {LEN_W{1'b0}};
      flags_q       <= '{good: 1'b1, runt: 1'b0, oversize: 1'b0};
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= end_s;
      if (end_s) begin
        frame_bytes_q <= bytes_end_s;
        flags_q       <= flags_d;
      end
    end
  end

  // Totals consume the record in the cycle it is presented.
  eth_stats_totals #(
    .LEN_W         (LEN_W),
    .CNT_W         (CNT_W),
    .CLEAR_ON_SNAP (CLEAR_ON_SNAP)
  ) u_totals (
    .clk           (clk),
    .rst_n         (rst_n),
    .add_valid_i   (frame_valid_q),
    .add_bytes_i   (frame_bytes_q),
    .add_bad_i     (~flags_q.good),
    .snap_req_i    (snapshot_req),
    .snap_frames_o (snap_frames),
    .snap_bytes_o  (snap_bytes),
    .snap_bad_o    (snap_bad),
    .snap_valid_o  (snap_valid)
  );

  assign frame_bytes    = frame_bytes_q;
  assign frame_good     = flags_q.good;
  assign frame_runt     = flags_q.runt;
  assign frame_oversize = flags_q.oversize;
  assign frame_valid    = frame_valid_q;

endmodule

// File: tb/tb_eth_frame_stats_monitor.sv
// Directed bench for eth_frame_stats_monitor. Three instances:
//   d0: 32-bit TX, LEN_W=16, totals kept across snapshots
//   d1: 32-bit RX, CLEAR_ON_SNAP=1
//   d2: 32-bit TX, LEN_W=8, CNT_W=16 (saturation and back-to-back frames)
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_eth_frame_stats_monitor;

  logic clk;
  logic rst_n;

  logic [2:0] rdy_s, vld_s, last_s, user_s, snap_s;
  logic [3:0] keep_s [3];

  wire [15:0] fb0, fb1;
  wire [7:0]  fb2;
  wire [2:0]  good_s, runt_s, over_s, fvalid_s, svalid_s;
  wire [63:0] sf0, sb0, sbd0, sf1, sb1, sbd1;
  wire [15:0] sf2, sb2, sbd2;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int fv_cnt [3] = '{0, 0, 0};

  logic [3:0] b2b_keep [4] = '{4'hF, 4'h1, 4'h3, 4'h7};
  int         b2b_len  [4] = '{4, 1, 2, 3};

  eth_frame_stats_monitor #(
    .DATA_W(32), .MODE(0), .LEN_W(16), .MIN_LEN(64), .MAX_LEN(1522),
    .CNT_W(64), .CLEAR_ON_SNAP(0)
  ) u_d0 (
    .clk(clk), .rst_n(rst_n),
    .axis_tready(rdy_s[0]), .axis_tvalid(vld_s[0]), .axis_tlast(last_s[0]),
    .axis_tkeep(keep_s[0]), .axis_tuser(user_s[0]), .snapshot_req(snap_s[0]),
    .frame_bytes(fb0), .frame_good(good_s[0]), .frame_runt(runt_s[0]),
    .frame_oversize(over_s[0]), .frame_valid(fvalid_s[0]),
    .snap_frames(sf0), .snap_bytes(sb0), .snap_bad(sbd0), .snap_valid(svalid_s[0])
  );

  eth_frame_stats_monitor #(
    .DATA_W(32), .MODE(1), .LEN_W(16), .MIN_LEN(64), .MAX_LEN(1522),
    .CNT_W(64), .CLEAR_ON_SNAP(1)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .axis_tready(rdy_s[1]), .axis_tvalid(vld_s[1]), .axis_tlast(last_s[1]),
    .axis_tkeep(keep_s[1]), .axis_tuser(user_s[1]), .snapshot_req(snap_s[1]),
    .frame_bytes(fb1), .frame_good(good_s[1]), .frame_runt(runt_s[1]),
    .frame_oversize(over_s[1]), .frame_valid(fvalid_s[1]),
    .snap_frames(sf1), .snap_bytes(sb1), .snap_bad(sbd1), .snap_valid(svalid_s[1])
  );

  eth_frame_stats_monitor #(
    .DATA_W(32), .MODE(0), .LEN_W(8), .MIN_LEN(64), .MAX_LEN(1522),
    .CNT_W(16), .CLEAR_ON_SNAP(0)
  ) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .axis_tready(rdy_s[2]), .axis_tvalid(vld_s[2]), .axis_tlast(last_s[2]),
    .axis_tkeep(keep_s[2]), .axis_tuser(user_s[2]), .snapshot_req(snap_s[2]),
    .frame_bytes(fb2), .frame_good(good_s[2]), .frame_runt(runt_s[2]),
    .frame_oversize(over_s[2]), .frame_valid(fvalid_s[2]),
    .snap_frames(sf2), .snap_bytes(sb2), .snap_bad(sbd2), .snap_valid(svalid_s[2])
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count frame_valid pulses per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      fv_cnt[k] <= fv_cnt[k] + (fvalid_s[k] ? 1 : 0);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle on instance d; every other instance sees an idle stream.
  task automatic drv(input int d, input int rdy, input int vld, input int last,
                     input logic [3:0] keep, input int user, input int snap);
    @(negedge clk);
    rdy_s  = 3'd0;
    vld_s  = 3'd0;
    last_s = 3'd0;
    user_s = 3'd0;
    snap_s = 3'd0;
    for (int k = 0; k < 3; k++) keep_s[k] = 4'h0;
    rdy_s[d]  = (rdy != 0);
    vld_s[d]  = (vld != 0);
    last_s[d] = (last != 0);
    user_s[d] = (user != 0);
    snap_s[d] = (snap != 0);
    keep_s[d] = keep;
  endtask

  task automatic idle(input int d);
    drv(d, 0, 0, 0, 4'h0, 0, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    rdy_s  = 3'd0;
    vld_s  = 3'd0;
    last_s = 3'd0;
    user_s = 3'd0;
    snap_s = 3'd0;
    for (int k = 0; k < 3; k++) keep_s[k] = 4'h0;
    repeat (3) @(negedge clk);

    // Reset state.
    check_eq("rst_bytes0", 64'(fb0), 64'd0);
    check_eq("rst_good0", 64'(good_s[0]), 64'd1);
    check_eq("rst_runt0", 64'(runt_s[0]), 64'd0);
    check_eq("rst_fvalid", 64'(fvalid_s), 64'd0);
    check_eq("rst_good_all", 64'(good_s), 64'd7);
    check_eq("rst_snap_frames1", sf1, 64'd0);
    check_eq("rst_svalid", 64'(svalid_s), 64'd0);
    rst_n = 1'b1;

    // TX: 15 full beats + keep=3 last beat = 62 bytes, runt.
    for (int i = 0; i < 15; i++) drv(0, 1, 1, 0, 4'hF, 0, 0);
    drv(0, 1, 1, 1, 4'h3, 0, 0);
    idle(0);
    check_eq("t1_fvalid", 64'(fvalid_s[0]), 64'd1);
    check_eq("t1_bytes", 64'(fb0), 64'd62);
    check_eq("t1_good", 64'(good_s[0]), 64'd1);
    check_eq("t1_runt", 64'(runt_s[0]), 64'd1);
    check_eq("t1_over", 64'(over_s[0]), 64'd0);
    idle(0);
    check_eq("t1_fvalid_off", 64'(fvalid_s[0]), 64'd0);
    check_eq("t1_bytes_held", 64'(fb0), 64'd62);
    check_eq("t1_pulses", 64'(fv_cnt[0]), 64'd1);

    // TX underrun after 20 full beats.
    for (int i = 0; i < 20; i++) drv(0, 1, 1, 0, 4'hF, 0, 0);
    drv(0, 1, 0, 0, 4'hF, 0, 0);
    idle(0);
    check_eq("t2_fvalid", 64'(fvalid_s[0]), 64'd1);
    check_eq("t2_good", 64'(good_s[0]), 64'd0);
    check_eq("t2_bytes", 64'(fb0), 64'd80);
    check_eq("t2_runt", 64'(runt_s[0]), 64'd0);
    drv(0, 0, 0, 0, 4'h0, 0, 1);
    idle(0);
    check_eq("t2_svalid", 64'(svalid_s[0]), 64'd1);
    check_eq("t2_snap_frames", sf0, 64'd2);
    check_eq("t2_snap_bytes", sb0, 64'd142);
    check_eq("t2_snap_bad", sbd0, 64'd1);
    idle(0);
    check_eq("t2_svalid_off", 64'(svalid_s[0]), 64'd0);

    // RX: 1522 bytes with 5 gaps, tuser on tlast (a mid-frame tuser is ignored).
    for (int i = 0; i < 380; i++) begin
      if (i == 50 || i == 100 || i == 150 || i == 200 || i == 250) drv(1, 1, 0, 0, 4'h0, 0, 0);
      drv(1, 1, 1, 0, 4'hF, (i == 3) ? 1 : 0, 0);
    end
    drv(1, 1, 1, 1, 4'h3, 1, 0);
    idle(1);
    check_eq("t3_fvalid", 64'(fvalid_s[1]), 64'd1);
    check_eq("t3_bytes", 64'(fb1), 64'd1522);
    check_eq("t3_good", 64'(good_s[1]), 64'd0);
    check_eq("t3_over", 64'(over_s[1]), 64'd0);
    check_eq("t3_runt", 64'(runt_s[1]), 64'd0);

    // RX: 1523 bytes, snapshot in the same cycle as its frame_valid.
    for (int i = 0; i < 380; i++) drv(1, 1, 1, 0, 4'hF, 0, 0);
    drv(1, 1, 1, 1, 4'h7, 0, 0);
    drv(1, 0, 0, 0, 4'h0, 0, 1);
    check_eq("t4_fvalid", 64'(fvalid_s[1]), 64'd1);
    check_eq("t4_bytes", 64'(fb1), 64'd1523);
    check_eq("t4_good", 64'(good_s[1]), 64'd1);
    check_eq("t4_over", 64'(over_s[1]), 64'd1);
    idle(1);
    check_eq("t4_svalid", 64'(svalid_s[1]), 64'd1);
    check_eq("t4_snap_frames", sf1, 64'd2);
    check_eq("t4_snap_bytes", sb1, 64'd3045);
    check_eq("t4_snap_bad", sbd1, 64'd1);
    drv(1, 0, 0, 0, 4'h0, 0, 1);
    idle(1);
    check_eq("t4_clr_svalid", 64'(svalid_s[1]), 64'd1);
    check_eq("t4_clr_frames", sf1, 64'd0);
    check_eq("t4_clr_bytes", sb1, 64'd0);
    check_eq("t4_clr_bad", sbd1, 64'd0);

    // LEN_W=8: 300 bytes saturate to 255, then back-to-back 1-beat frames.
    for (int i = 0; i < 74; i++) drv(2, 1, 1, 0, 4'hF, 0, 0);
    drv(2, 1, 1, 1, 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drv(2, 1, 1, 1, b2b_keep[i], 0, 0);
      check_eq("t5_b2b_fvalid", 64'(fvalid_s[2]), 64'd1);
      if (i == 0) begin
        check_eq("t5_sat_bytes", 64'(fb2), 64'd255);
        check_eq("t5_sat_runt", 64'(runt_s[2]), 64'd0);
        check_eq("t5_sat_over", 64'(over_s[2]), 64'd0);
      end else begin
        check_eq("t5_b2b_bytes", 64'(fb2), 64'(b2b_len[i-1]));
      end
    end
    idle(2);
    check_eq("t5_b2b_last_fvalid", 64'(fvalid_s[2]), 64'd1);
    check_eq("t5_b2b_last_bytes", 64'(fb2), 64'd3);
    drv(2, 0, 0, 0, 4'h0, 0, 1);
    idle(2);
    check_eq("t5_pulses", 64'(fv_cnt[2]), 64'd5);
    check_eq("t5_snap_frames", 64'(sf2), 64'd5);
    check_eq("t5_snap_bytes", 64'(sb2), 64'd265);
    check_eq("t5_snap_bad", 64'(sbd2), 64'd0);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 5; i++) drv(0, 1, 1, 0, 4'hF, 0, 0);
    idle(0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t6_rst_bytes", 64'(fb0), 64'd0);
    check_eq("t6_rst_good", 64'(good_s[0]), 64'd1);
    check_eq("t6_rst_snap_frames", sf0, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) drv(0, 1, 1, 0, 4'hF, 0, 0);
    drv(0, 1, 1, 1, 4'hF, 0, 0);
    idle(0);
    check_eq("t6_fvalid", 64'(fvalid_s[0]), 64'd1);
    check_eq("t6_bytes", 64'(fb0), 64'd12);
    check_eq("t6_good", 64'(good_s[0]), 64'd1);
    drv(0, 0, 0, 0, 4'h0, 0, 1);
    idle(0);
    check_eq("t6_snap_frames", sf0, 64'd1);
    check_eq("t6_snap_bytes", sb0, 64'd12);
    check_eq("t6_snap_bad", sbd0, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
